// File: rtl/sm4_iter_core.sv
// Iterative SM4 cipher core: ROUNDS_PER_CYCLE chained rounds per clock, one block in flight,
// valid/ready on both sides with a user tag carried alongside the block.
//
// state | meaning
// IDLE  | ready for a new block
// BUSY  | rounds in progress, rc_q = first round index of this iteration
// DONE  | result held on DAT_o/TAG_o until downstream accepts
module sm4_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 4,
   parameter int TAG_W            = 4
) (
   input  logic               CLK_i,
   input  logic               RST_i,
   input  logic [1023:0]      RK_i,
   input  logic               MODE_i,
   input  logic [127:0]       DAT_i,
   input  logic [TAG_W-1:0]   TAG_i,
   input  logic               IN_VALID_i,
   output logic               IN_READY_o,
   output logic [127:0]       DAT_o,
   output logic [TAG_W-1:0]   TAG_o,
   output logic               OUT_VALID_o,
   input  logic               OUT_READY_i
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
      $error("sm4_iter_core: ROUNDS_PER_CYCLE must be 1,2,4,8,16 or 32");
   end

   localparam logic [4:0] RC_STEP = 5'(ROUNDS_PER_CYCLE % 32);
   localparam logic [4:0] RC_LAST = 5'(32 - ROUNDS_PER_CYCLE);

   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

   function automatic logic [31:0] tau(input logic [31:0] a);
      return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
   endfunction

   function automatic logic [31:0] lin(input logic [31:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [127:0]       x_q, x_d;
   logic [4:0]         rc_q, rc_d;
   logic               mode_q, mode_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [127:0]       dat_o_q, dat_o_d;
   logic [TAG_W-1:0]   tag_o_q, tag_o_d;
   logic               out_valid_q, out_valid_d;

   logic [31:0]  rk_arr [32];
   logic [127:0] round_out;
   logic [127:0] result;
   logic         in_ready;
   logic         in_fire;

   for (genvar g = 0; g < 32; g++) begin : g_rk
      assign rk_arr[g] = RK_i[1023-32*g -: 32];
   end

   always_comb begin
      logic [31:0] w0, w1, w2, w3, nw;
      logic [4:0]  idx, kidx;
      w0   = x_q[127:96];
      w1   = x_q[95:64];
      w2   = x_q[63:32];
      w3   = x_q[31:0];
      nw   = '0;
      idx  = '0;
      kidx = '0;
      for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         idx  = rc_q + 5'(r);
         kidx = mode_q ? (5'd31 - idx) : idx;
         nw   = w0 ^ lin(tau(w1 ^ w2 ^ w3 ^ rk_arr[kidx]));
         w0   = w1;
         w1   = w2;
         w2   = w3;
         w3   = nw;
      end
      round_out = {w0, w1, w2, w3};
   end

   // output word order is reversed: {X35,X34,X33,X32}
   assign result = {round_out[31:0], round_out[63:32], round_out[95:64], round_out[127:96]};

   assign in_ready   = (state_q == IDLE) || (state_q == DONE && OUT_READY_i);
   assign in_fire    = in_ready && IN_VALID_i;
   assign IN_READY_o = in_ready && !RST_i;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      rc_d        = rc_q;
      mode_d      = mode_q;
      tag_d       = tag_q;
      dat_o_d     = dat_o_q;
      tag_o_d     = tag_o_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (IN_VALID_i) state_d = BUSY;
         end
         BUSY: begin
            x_d  = round_out;
            rc_d = rc_q + RC_STEP;
            if (rc_q == RC_LAST) begin
               dat_o_d     = result;
               tag_o_d     = tag_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (OUT_READY_i) begin
               out_valid_d = 1'b0;
               state_d     = IN_VALID_i ? BUSY : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (in_fire) begin
         x_d    = DAT_i;
         mode_d = MODE_i;
         tag_d  = TAG_i;
         rc_d   = '0;
      end
   end

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         state_q     <= IDLE;
         x_q         <= '0;
         rc_q        <= '0;
         mode_q      <= 1'b0;
         tag_q       <= '0;
         dat_o_q     <= '0;
         tag_o_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         rc_q        <= rc_d;
         mode_q      <= mode_d;
         tag_q       <= tag_d;
         dat_o_q     <= dat_o_d;
         tag_o_q     <= tag_o_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign DAT_o       = dat_o_q;
   assign TAG_o       = tag_o_q;
   assign OUT_VALID_o = out_valid_q;

endmodule

// File: tb/tb_sm4_iter_core.sv
// Self-checking bench for sm4_iter_core: reference SM4 model plus scoreboard on the default
// instance, and a latency/result sweep over other ROUNDS_PER_CYCLE values.
module tb_sm4_iter_core;
   localparam int TAG_W = 4;
   localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

   localparam logic [0:255][7:0] M_SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
   localparam logic [0:3][31:0] M_FK = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [1023:0]      rk;
   logic               mode;
   logic [127:0]       dat_in;
   logic [TAG_W-1:0]   tag_in;
   logic               in_valid, in_valid_sw, out_ready;
   logic               in_ready, out_valid;
   logic [127:0]       dat_out;
   logic [TAG_W-1:0]   tag_out;
   logic [3:0]         sw_ready, sw_valid;
   logic [127:0]       sw_dat [4];
   logic [TAG_W-1:0]   sw_tag [4];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_acc;

   typedef struct {
      logic [127:0]     dat;
      logic [TAG_W-1:0] tag;
      int               acc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sm4_iter_core #(.ROUNDS_PER_CYCLE(4), .TAG_W(TAG_W)) dut (
      .CLK_i(clk), .RST_i(rst), .RK_i(rk), .MODE_i(mode), .DAT_i(dat_in), .TAG_i(tag_in),
      .IN_VALID_i(in_valid), .IN_READY_o(in_ready), .DAT_o(dat_out), .TAG_o(tag_out),
      .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready));

   sm4_iter_core #(.ROUNDS_PER_CYCLE(1), .TAG_W(TAG_W)) u_r1 (
      .CLK_i(clk), .RST_i(rst), .RK_i(rk), .MODE_i(mode), .DAT_i(dat_in), .TAG_i(tag_in),
      .IN_VALID_i(in_valid_sw), .IN_READY_o(sw_ready[0]), .DAT_o(sw_dat[0]), .TAG_o(sw_tag[0]),
      .OUT_VALID_o(sw_valid[0]), .OUT_READY_i(1'b1));
   sm4_iter_core #(.ROUNDS_PER_CYCLE(2), .TAG_W(TAG_W)) u_r2 (
      .CLK_i(clk), .RST_i(rst), .RK_i(rk), .MODE_i(mode), .DAT_i(dat_in), .TAG_i(tag_in),
      .IN_VALID_i(in_valid_sw), .IN_READY_o(sw_ready[1]), .DAT_o(sw_dat[1]), .TAG_o(sw_tag[1]),
      .OUT_VALID_o(sw_valid[1]), .OUT_READY_i(1'b1));
   sm4_iter_core #(.ROUNDS_PER_CYCLE(8), .TAG_W(TAG_W)) u_r8 (
      .CLK_i(clk), .RST_i(rst), .RK_i(rk), .MODE_i(mode), .DAT_i(dat_in), .TAG_i(tag_in),
      .IN_VALID_i(in_valid_sw), .IN_READY_o(sw_ready[2]), .DAT_o(sw_dat[2]), .TAG_o(sw_tag[2]),
      .OUT_VALID_o(sw_valid[2]), .OUT_READY_i(1'b1));
   sm4_iter_core #(.ROUNDS_PER_CYCLE(32), .TAG_W(TAG_W)) u_r32 (
      .CLK_i(clk), .RST_i(rst), .RK_i(rk), .MODE_i(mode), .DAT_i(dat_in), .TAG_i(tag_in),
      .IN_VALID_i(in_valid_sw), .IN_READY_o(sw_ready[3]), .DAT_o(sw_dat[3]), .TAG_o(sw_tag[3]),
      .OUT_VALID_o(sw_valid[3]), .OUT_READY_i(1'b1));

   task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] m_tau(input logic [31:0] a);
      return {M_SBOX[a[31:24]], M_SBOX[a[23:16]], M_SBOX[a[15:8]], M_SBOX[a[7:0]]};
   endfunction

   function automatic logic [31:0] m_l(input logic [31:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

   function automatic logic [31:0] m_lk(input logic [31:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   function automatic logic [1023:0] m_keyexp(input logic [127:0] mk);
      logic [31:0]   k [36];
      logic [31:0]   ck;
      logic [1023:0] out;
      out = '0;
      for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ M_FK[i];
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
         k[i+4] = k[i] ^ m_lk(m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck));
         out[1023-32*i -: 32] = k[i+4];
      end
      return out;
   endfunction

   function automatic logic [127:0] m_crypt(input logic [127:0] din, input logic [1023:0] rkv,
                                            input logic md);
      logic [31:0] x [36];
      int          ki;
      for (int i = 0; i < 4; i++) x[i] = din[127-32*i -: 32];
      for (int i = 0; i < 32; i++) begin
         ki = md ? 31 - i : i;
         x[i+4] = x[i] ^ m_l(m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rkv[1023-32*ki -: 32]));
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   // Drives one block and waits (bounded) for its acceptance; expectation pushed on accept.
   task automatic send(input logic [127:0] d, input logic m, input logic [TAG_W-1:0] t,
                       input logic [127:0] exp, input bit hold);
      int k;
      dat_in   = d;
      mode     = m;
      tag_in   = t;
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         k++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check_eq("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         sb.push_back('{dat: exp, tag: t, acc: cyc});
         last_acc = cyc;
         @(posedge clk);
         #1;
         if (!hold) in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() > 0 && k < 200) begin
         k++;
         @(negedge clk);
      end
      if (sb.size() > 0) check_eq("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every output transfer of the default instance.
   initial begin
      bit   prev_valid;
      int   rise;
      exp_t e;
      prev_valid = 1'b0;
      rise = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) rise = cyc;
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check_eq("unexpected_out", out_valid, 0);
               end else begin
                  e = sb.pop_front();
                  check_eq("out_dat", dat_out, e.dat);
                  check_eq("out_tag", tag_out, e.tag);
                  check_eq("latency", rise - e.acc - 1, 8);
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] d;
      int           acc [4];
      int           seen, c0, k;
      int           sw_rise [4];
      logic [127:0] sw_res [4];
      int           sw_lat [4];
      sw_lat[0] = 32; sw_lat[1] = 16; sw_lat[2] = 4; sw_lat[3] = 1;

      in_valid = 1'b0; in_valid_sw = 1'b0; out_ready = 1'b1;
      mode = 1'b0; dat_in = '0; tag_in = '0;
      rk = m_keyexp(PT);

      #8;
      check_eq("rst_dat", dat_out, 0);
      check_eq("rst_tag", tag_out, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", in_ready, 1);
      @(posedge clk);
      #1;

      send(PT, 1'b0, 4'h5, CT, 1'b0);
      drain();
      send(CT, 1'b1, 4'ha, PT, 1'b0);
      drain();

      // back-pressure: output held, new input offered but must not be taken
      out_ready = 1'b0;
      send(PT, 1'b0, 4'h7, CT, 1'b0);
      k = 0;
      while (!out_valid && k < 50) begin
         k++;
         @(posedge clk);
         #1;
      end
      check_eq("bp_valid_rise", out_valid, 1);
      dat_in = 128'hdeadbeef_00000000_11111111_22222222;
      tag_in = 4'hc;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("bp_dat", dat_out, CT);
         check_eq("bp_tag", tag_out, 4'h7);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (12) @(posedge clk);
      #1;
      check_eq("bp_single_xfer", out_valid, 0);

      // back-to-back with IN_VALID held high
      for (int i = 1; i <= 3; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         send(d, (i == 2), 4'(i), m_crypt(d, rk, (i == 2)), (i < 3));
         acc[i] = last_acc;
      end
      check_eq("b2b_gap12", acc[2] - acc[1], 9);
      check_eq("b2b_gap23", acc[3] - acc[2], 9);
      drain();

      // reset in the middle of BUSY
      send(PT, 1'b0, 4'h9, CT, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_ready", in_ready, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq("midrst_no_out", seen, 0);
      @(posedge clk);
      #1;
      send(PT, 1'b0, 4'h3, CT, 1'b0);
      drain();

      // ROUNDS_PER_CYCLE sweep
      dat_in = PT;
      mode = 1'b0;
      tag_in = 4'h6;
      in_valid_sw = 1'b1;
      @(negedge clk);
      check_eq("sw_ready", sw_ready, 4'hf);
      c0 = cyc;
      @(posedge clk);
      #1;
      in_valid_sw = 1'b0;
      for (int j = 0; j < 4; j++) begin
         sw_rise[j] = -1;
         sw_res[j] = '0;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) begin
            if (sw_valid[j] && sw_rise[j] < 0) begin
               sw_rise[j] = cyc;
               sw_res[j] = sw_dat[j];
               check_eq($sformatf("sw_tag_%0d", j), sw_tag[j], 4'h6);
            end
         end
      end
      for (int j = 0; j < 4; j++) begin
         check_eq($sformatf("sw_dat_%0d", j), sw_res[j], CT);
         check_eq($sformatf("sw_lat_%0d", j), sw_rise[j] - c0 - 1, sw_lat[j]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
